// File: rtl/ctl_sequencer.sv
// ctl_sequencer: hardwired fetch/execute control sequencer.
// Walks T0..T5 (with an optional memory-wait step T1W) and drives the
// datapath control strobes. Strobes are decoded from the state register
// (and IR in T3/T4), so they drop as soon as Reset_n asserts.
module ctl_sequencer #(
  parameter int OPC_W    = 5,
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 4
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Run,
  input  logic [31:0]        IR,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               Zin,
  output logic               Read,
  output logic               MDRin,
  output logic               PCin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               Yin,
  output logic               Cout,
  output logic               ZLOout,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [3:0]         Tstate,
  output logic               Running,
  output logic               Illegal,
  output logic               Halted
);

  // State codes double as the Tstate output value.
  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T1W  = 4'd7,
    S_HALT = 4'd8
  } state_e;

  localparam logic [OPC_W-1:0] OPC_ADD  = OPC_W'(5'b00011);
  localparam logic [OPC_W-1:0] OPC_SUB  = OPC_W'(5'b00100);
  localparam logic [OPC_W-1:0] OPC_AND  = OPC_W'(5'b00101);
  localparam logic [OPC_W-1:0] OPC_OR   = OPC_W'(5'b00110);
  localparam logic [OPC_W-1:0] OPC_ADDI = OPC_W'(5'b01100);
  localparam logic [OPC_W-1:0] OPC_ANDI = OPC_W'(5'b01101);
  localparam logic [OPC_W-1:0] OPC_ORI  = OPC_W'(5'b01110);
  localparam logic [OPC_W-1:0] OPC_NOP  = OPC_W'(5'b11010);
  localparam logic [OPC_W-1:0] OPC_HALT = OPC_W'(5'b11011);

  localparam logic [ALUOP_W-1:0] ALU_INC = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(5);

  // Wait counter preload; T1W lasts MEM_WAIT cycles (counts down to 0).
  localparam logic [2:0] WAIT_INIT = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [OPC_W-1:0]     opc;
  logic                 is_reg, is_imm, is_alu, is_nop, is_halt, bad_opc;
  logic [ALUOP_W-1:0]   op_alu;

  // Only the opcode field steers control; operand fields go to the datapath.
  logic                 unused_ir;
  assign unused_ir = ^IR[31-OPC_W:0];
  assign opc       = IR[31 -: OPC_W];

  // Opcode classification and ALU function select.
  always_comb begin
    is_reg  = 1'b0;
    is_imm  = 1'b0;
    is_nop  = 1'b0;
    is_halt = 1'b0;
    op_alu  = '0;
    case (opc)
      OPC_ADD:  begin is_reg = 1'b1; op_alu = ALU_ADD; end
      OPC_SUB:  begin is_reg = 1'b1; op_alu = ALU_SUB; end
      OPC_AND:  begin is_reg = 1'b1; op_alu = ALU_AND; end
      OPC_OR:   begin is_reg = 1'b1; op_alu = ALU_OR;  end
      OPC_ADDI: begin is_imm = 1'b1; op_alu = ALU_ADD; end
      OPC_ANDI: begin is_imm = 1'b1; op_alu = ALU_AND; end
      OPC_ORI:  begin is_imm = 1'b1; op_alu = ALU_OR;  end
      OPC_NOP:  is_nop  = 1'b1;
      OPC_HALT: is_halt = 1'b1;
      default:  ;
    endcase
    is_alu  = is_reg | is_imm;
    bad_opc = ~(is_alu | is_nop | is_halt);
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (Run) state_d = S_T0;
      S_T0: begin
        if (MEM_WAIT > 0) begin
          state_d = S_T1W;
          cnt_d   = WAIT_INIT;
        end else begin
          state_d = S_T1;
        end
      end
      S_T1W: begin
        if (cnt_q == 3'd0) state_d = S_T1;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_T1: state_d = S_T2;
      S_T2: state_d = S_T3;
      // nop and unknown opcodes end the instruction here.
      S_T3: begin
        if (is_alu)       state_d = S_T4;
        else if (is_halt) state_d = S_HALT;
        else              state_d = Run ? S_T0 : S_IDLE;
      end
      S_T4:   state_d = S_T5;
      S_T5:   state_d = Run ? S_T0 : S_IDLE;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // State register and wait counter; HALT is left only through reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobe decode; everything defaults low so undefined states are quiet.
  always_comb begin
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    PCin    = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    Yin     = 1'b0;
    Cout    = 1'b0;
    ZLOout  = 1'b0;
    alu_op  = '0;
    Illegal = 1'b0;
    case (state_q)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        alu_op = ALU_INC;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      // Last read cycle also commits the incremented PC from Z.
      S_T1: begin
        Read   = 1'b1;
        MDRin  = 1'b1;
        ZLOout = 1'b1;
        PCin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (is_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
        Illegal = bad_opc;
      end
      S_T4: begin
        if (is_reg) begin
          Grc    = 1'b1;
          Rout   = 1'b1;
          Zin    = 1'b1;
          alu_op = op_alu;
        end else if (is_imm) begin
          Cout   = 1'b1;
          Zin    = 1'b1;
          alu_op = op_alu;
        end
      end
      S_T5: begin
        ZLOout = 1'b1;
        Gra    = 1'b1;
        Rin    = 1'b1;
      end
      default: ;
    endcase
  end

  assign Tstate  = state_q;
  assign Running = (state_q != S_IDLE) && (state_q != S_HALT);
  assign Halted  = (state_q == S_HALT);

endmodule
